// File: rtl/uart_pkg.sv
// Shared receiver state encoding and parity-sense constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } rx_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous level; 2 clk latency, reset value is a parameter.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: rx_valid rises 1 clk after the stop-bit sample tick.
// Holds a word until rx_ready; a frame finishing while a word is pending is dropped with an overrun pulse.
module uart_rx_oversampled #(
    parameter int DATA_BITS    = 8,
    parameter int OVERSAMPLING = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    import uart_pkg::*;

    localparam int SW = $clog2(OVERSAMPLING);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [SW-1:0] MID      = SW'(OVERSAMPLING / 2 - 1);
    localparam logic [SW-1:0] LAST     = SW'(OVERSAMPLING - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          W_SENSE  = (PARITY_ODD != 0) ? uart_pkg::PARITY_ODD : PARITY_EVEN;

    rx_state_e r_state;
    rx_state_e w_next;

    logic                 w_rx_s;
    logic [SW-1:0]        r_sample_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    logic w_at_mid;
    logic w_at_last;
    logic w_shift_en;
    logic w_par_en;
    logic w_complete;
    logic w_load;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (rx),
        .o_sync  (w_rx_s)
    );

    assign w_at_mid  = (r_sample_cnt == MID);
    assign w_at_last = (r_sample_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (tick) begin
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) w_next = START;
                end
                START: begin
                    if (w_at_mid) begin
                        if (w_rx_s) w_next = IDLE;
                        else        w_next = DATA;
                    end
                end
                DATA: begin
                    if (w_at_last && (r_bit_cnt == BIT_LAST)) begin
                        if (PARITY_EN != 0) w_next = PARITY;
                        else                w_next = STOP;
                    end
                end
                PARITY: begin
                    if (w_at_last) w_next = STOP;
                end
                STOP: begin
                    if (w_at_last) begin
                        if (w_rx_s) w_next = IDLE;
                        else        w_next = BREAK_WAIT;
                    end
                end
                BREAK_WAIT: begin
                    if (w_rx_s) w_next = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        w_shift_en = 1'b0;
        w_par_en   = 1'b0;
        w_complete = 1'b0;
        if (tick && w_at_last) begin
            w_shift_en = (r_state == DATA);
            w_par_en   = (r_state == PARITY);
            w_complete = (r_state == STOP);
        end
    end

    // Sample counter restarts on every state change, so DATA/PARITY/STOP samples land mid-bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_err    <= 1'b0;
        end else if (tick) begin
            if ((w_next != r_state) || w_at_last || (r_state == IDLE) || (r_state == BREAK_WAIT)) begin
                r_sample_cnt <= '0;
            end else begin
                r_sample_cnt <= r_sample_cnt + 1'b1;
            end
            if (r_state == START) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_shift_en) begin
                r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            end
            if (w_par_en) begin
                r_par_err <= (^r_shift) ^ w_rx_s ^ W_SENSE;
            end
        end
    end

    assign w_load = w_complete && (!r_valid || rx_ready);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= w_complete && r_valid && !rx_ready;
            if (w_load) begin
                r_data       <= r_shift;
                r_frame_err  <= ~w_rx_s;
                r_parity_err <= r_par_err;
                r_valid      <= 1'b1;
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: an 8N1 instance and an even-parity instance on a shared clock/tick.
module tb_uart_rx_oversampled;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick = 1'b0;
    logic rx0 = 1'b1, rx1 = 1'b1;
    logic rdy0 = 1'b1, rdy1 = 1'b1;
    logic [7:0] data0, data1;
    logic vld0, vld1, fe0, fe1, pe0, pe1, ov0, ov1;

    int checks = 0;
    int failures = 0;
    int tcnt = 0;

    logic [9:0] got0[$];
    logic [9:0] got1[$];
    int ov_cnt0 = 0, ov_cnt1 = 0, vcyc0 = 0, vcyc1 = 0;

    localparam int BIT_CLK = 64;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tcnt = (tcnt + 1) % 4;
        tick = (tcnt == 0);
    end

    uart_rx_oversampled dut0 (
        .clk(clk), .reset(reset), .tick(tick), .rx(rx0),
        .rx_data(data0), .rx_valid(vld0), .rx_ready(rdy0),
        .frame_err(fe0), .parity_err(pe0), .overrun(ov0)
    );

    uart_rx_oversampled #(.PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .reset(reset), .tick(tick), .rx(rx1),
        .rx_data(data1), .rx_valid(vld1), .rx_ready(rdy1),
        .frame_err(fe1), .parity_err(pe1), .overrun(ov1)
    );

    // Record every accepted word as {parity_err, frame_err, data}.
    always @(negedge clk) begin
        #1;
        if (reset) begin
            if (vld0) vcyc0++;
            if (vld1) vcyc1++;
            if (vld0 && rdy0) got0.push_back({pe0, fe0, data0});
            if (vld1 && rdy1) got1.push_back({pe1, fe1, data1});
            if (ov0) ov_cnt0++;
            if (ov1) ov_cnt1++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] model(input logic [7:0] d, input logic stop,
                                         input bit par_en, input logic par);
        logic pe;
        pe = par_en ? ((($countones(d) + int'(par)) % 2) != 0) : 1'b0;
        return {pe, ~stop, d};
    endfunction

    task automatic drive(input int inst, input logic v);
        if (inst == 0) rx0 = v;
        else           rx1 = v;
    endtask

    task automatic hold_bits(input int n);
        repeat (n * BIT_CLK) @(negedge clk);
    endtask

    task automatic idle(input int inst, input int n_clk);
        drive(inst, 1'b1);
        repeat (n_clk) @(negedge clk);
    endtask

    // Leaves the line at the stop-bit level; the caller decides what follows.
    task automatic send_frame(input int inst, input logic [7:0] d, input logic stop,
                              input bit par_en, input logic par);
        drive(inst, 1'b0);
        hold_bits(1);
        for (int i = 0; i < 8; i++) begin
            drive(inst, d[i]);
            hold_bits(1);
        end
        if (par_en) begin
            drive(inst, par);
            hold_bits(1);
        end
        drive(inst, stop);
        hold_bits(1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if ({data0, vld0, fe0, pe0, ov0} !== 12'h000) begin
            failures++;
            $display("FAIL reset_dut0: got %h expected 000", {data0, vld0, fe0, pe0, ov0});
        end
        checks++;
        if ({data1, vld1, fe1, pe1, ov1} !== 12'h000) begin
            failures++;
            $display("FAIL reset_dut1: got %h expected 000", {data1, vld1, fe1, pe1, ov1});
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_basic();
        int v0, o0;
        logic [9:0] exp_w;
        got0.delete();
        v0 = vcyc0;
        o0 = ov_cnt0;
        exp_w = model(8'hA5, 1'b1, 0, 1'b0);
        send_frame(0, 8'hA5, 1'b1, 0, 1'b0);
        idle(0, BIT_CLK);
        checks++;
        if (got0.size() != 1) begin
            failures++;
            $display("FAIL basic_count: got %0d words expected 1", got0.size());
        end else if (got0[0] !== exp_w) begin
            failures++;
            $display("FAIL basic_word: got %h expected %h", got0[0], exp_w);
        end
        checks++;
        if (vcyc0 - v0 != 1) begin
            failures++;
            $display("FAIL basic_valid_width: got %0d cycles expected 1", vcyc0 - v0);
        end
        checks++;
        if (ov_cnt0 - o0 != 0) begin
            failures++;
            $display("FAIL basic_overrun: got %0d pulses expected 0", ov_cnt0 - o0);
        end
    endtask

    task automatic test_false_start();
        int v0;
        logic [7:0] d;
        logic [9:0] exp_w;
        got0.delete();
        v0 = vcyc0;
        drive(0, 1'b0);
        repeat (16) @(negedge clk);
        drive(0, 1'b1);
        repeat (24) @(negedge clk);
        checks++;
        if (vcyc0 != v0) begin
            failures++;
            $display("FAIL false_start_valid: got %0d valid cycles expected 0", vcyc0 - v0);
        end
        d = 8'($urandom);
        exp_w = model(d, 1'b1, 0, 1'b0);
        send_frame(0, d, 1'b1, 0, 1'b0);
        idle(0, BIT_CLK);
        checks++;
        if (got0.size() != 1) begin
            failures++;
            $display("FAIL false_start_count: got %0d words expected 1", got0.size());
        end else if (got0[0] !== exp_w) begin
            failures++;
            $display("FAIL false_start_next: got %h expected %h", got0[0], exp_w);
        end
    endtask

    task automatic test_break();
        logic [9:0] exp_a, exp_b;
        got0.delete();
        exp_a = model(8'h3C, 1'b0, 0, 1'b0);
        exp_b = model(8'h81, 1'b1, 0, 1'b0);
        send_frame(0, 8'h3C, 1'b0, 0, 1'b0);
        hold_bits(3);
        checks++;
        if (got0.size() != 1) begin
            failures++;
            $display("FAIL break_count: got %0d words expected 1", got0.size());
        end else if (got0[0] !== exp_a) begin
            failures++;
            $display("FAIL break_word: got %h expected %h", got0[0], exp_a);
        end
        idle(0, BIT_CLK);
        send_frame(0, 8'h81, 1'b1, 0, 1'b0);
        idle(0, BIT_CLK);
        checks++;
        if (got0.size() != 2) begin
            failures++;
            $display("FAIL break_after_count: got %0d words expected 2", got0.size());
        end else if (got0[1] !== exp_b) begin
            failures++;
            $display("FAIL break_after_word: got %h expected %h", got0[1], exp_b);
        end
    endtask

    task automatic test_overrun();
        int o0;
        logic [9:0] exp_w;
        got0.delete();
        o0 = ov_cnt0;
        exp_w = model(8'h11, 1'b1, 0, 1'b0);
        rdy0 = 1'b0;
        send_frame(0, 8'h11, 1'b1, 0, 1'b0);
        idle(0, 32);
        send_frame(0, 8'h22, 1'b1, 0, 1'b0);
        idle(0, BIT_CLK);
        checks++;
        if (ov_cnt0 - o0 != 1) begin
            failures++;
            $display("FAIL overrun_pulses: got %0d expected 1", ov_cnt0 - o0);
        end
        checks++;
        if ({pe0, fe0, data0} !== exp_w || vld0 !== 1'b1) begin
            failures++;
            $display("FAIL overrun_held: got %h vld %b expected %h vld 1", {pe0, fe0, data0}, vld0, exp_w);
        end
        rdy0 = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (got0.size() != 1) begin
            failures++;
            $display("FAIL overrun_drain_count: got %0d words expected 1", got0.size());
        end else if (got0[0] !== exp_w) begin
            failures++;
            $display("FAIL overrun_drain_word: got %h expected %h", got0[0], exp_w);
        end
        checks++;
        if (vld0 !== 1'b0) begin
            failures++;
            $display("FAIL overrun_valid_fall: got %b expected 0", vld0);
        end
    endtask

    task automatic test_parity();
        logic [9:0] exp_a, exp_b;
        got1.delete();
        exp_a = model(8'h07, 1'b1, 1, 1'b0);
        exp_b = model(8'h07, 1'b1, 1, 1'b1);
        send_frame(1, 8'h07, 1'b1, 1, 1'b0);
        idle(1, BIT_CLK);
        send_frame(1, 8'h07, 1'b1, 1, 1'b1);
        idle(1, BIT_CLK);
        checks++;
        if (got1.size() != 2) begin
            failures++;
            $display("FAIL parity_count: got %0d words expected 2", got1.size());
        end else begin
            checks++;
            if (got1[0] !== exp_a) begin
                failures++;
                $display("FAIL parity_bad: got %h expected %h", got1[0], exp_a);
            end
            if (got1[1] !== exp_b) begin
                failures++;
                $display("FAIL parity_good: got %h expected %h", got1[1], exp_b);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic [9:0] exp_w;
        got0.delete();
        d = 8'hE7;
        drive(0, 1'b0);
        hold_bits(1);
        for (int i = 0; i < 3; i++) begin
            drive(0, d[i]);
            hold_bits(1);
        end
        drive(0, d[3]);
        repeat (BIT_CLK / 2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({data0, vld0, fe0, pe0, ov0} !== 12'h000) begin
            failures++;
            $display("FAIL reset_mid_outputs: got %h expected 000", {data0, vld0, fe0, pe0, ov0});
        end
        idle(0, 2 * BIT_CLK);
        checks++;
        if (got0.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_lost: got %0d words expected 0", got0.size());
        end
        exp_w = model(8'h5A, 1'b1, 0, 1'b0);
        send_frame(0, 8'h5A, 1'b1, 0, 1'b0);
        idle(0, BIT_CLK);
        checks++;
        if (got0.size() != 1) begin
            failures++;
            $display("FAIL reset_mid_next_count: got %0d words expected 1", got0.size());
        end else if (got0[0] !== exp_w) begin
            failures++;
            $display("FAIL reset_mid_next_word: got %h expected %h", got0[0], exp_w);
        end
    endtask

    task automatic test_random(input int inst, input int n);
        logic [9:0] exp_q[$];
        logic [7:0] d;
        logic stop, par;
        if (inst == 0) got0.delete();
        else           got1.delete();
        for (int k = 0; k < n; k++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            par  = 1'($urandom_range(0, 1));
            exp_q.push_back(model(d, stop, inst == 1, par));
            send_frame(inst, d, stop, inst == 1, par);
            idle(inst, $urandom_range(8, 40));
        end
        idle(inst, BIT_CLK);
        checks++;
        if (((inst == 0) ? got0.size() : got1.size()) != exp_q.size()) begin
            failures++;
            $display("FAIL random%0d_count: got %0d words expected %0d", inst,
                     (inst == 0) ? got0.size() : got1.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (((inst == 0) ? got0[k] : got1[k]) !== exp_q[k]) begin
                    failures++;
                    $display("FAIL random%0d_word%0d: got %h expected %h", inst, k,
                             (inst == 0) ? got0[k] : got1[k], exp_q[k]);
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_false_start();
        test_break();
        test_overrun();
        test_parity();
        test_reset_mid();
        test_random(0, 10);
        test_random(1, 6);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
